// File: rtl/branch_scanner_pkg.sv
// Shared BeeF core definitions: opcodes plus the bracket-scanner state and direction types.
package definitions;

  typedef enum logic [3:0] {
    NOP     = 4'h0,
    INC_DP  = 4'h1,
    DEC_DP  = 4'h2,
    INC_ACC = 4'h3,
    DEC_ACC = 4'h4,
    OUT_ACC = 4'h5,
    IN_ACC  = 4'h6,
    CBF     = 4'h7,
    CBB     = 4'h8,
    HALT    = 4'h9
  } op_code;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_RESOLVE
  } scan_state_e;

  typedef enum logic {
    DIR_FWD,
    DIR_BWD
  } scan_dir_e;

  function automatic scan_dir_e branch_dir(input op_code op);
    return (op == CBB) ? DIR_BWD : DIR_FWD;
  endfunction

endpackage

// File: rtl/branch_scanner_cache.sv
// Fully associative jump-target cache keyed on {pc, direction}; round-robin replacement.
module jump_target_cache
  import definitions::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned CACHE_ENTRIES = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_lk_pc,
  input  scan_dir_e         i_lk_dir,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_target,
  input  logic              i_ins,
  input  logic [ADDR_W-1:0] i_ins_pc,
  input  scan_dir_e         i_ins_dir,
  input  logic [ADDR_W-1:0] i_ins_target
);

  generate
    if (CACHE_ENTRIES == 0) begin : g_none
      logic w_unused;
      assign w_unused = ^{i_clk, i_rst_n, i_flush, i_lk_pc, i_lk_dir,
                          i_ins, i_ins_pc, i_ins_dir, i_ins_target};
      assign o_hit    = 1'b0;
      assign o_target = '0;
    end else begin : g_cache
      localparam int unsigned IDX_W = (CACHE_ENTRIES > 1) ? $clog2(CACHE_ENTRIES) : 1;
      localparam int unsigned LAST  = CACHE_ENTRIES - 1;

      logic              r_valid [CACHE_ENTRIES];
      logic [ADDR_W-1:0] r_pc    [CACHE_ENTRIES];
      scan_dir_e         r_dir   [CACHE_ENTRIES];
      logic [ADDR_W-1:0] r_tgt   [CACHE_ENTRIES];
      logic [IDX_W-1:0]  r_rr;
      logic              w_match;
      logic [IDX_W-1:0]  w_match_idx;

      always_comb begin
        o_hit       = 1'b0;
        o_target    = '0;
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
          if (r_valid[i] && r_pc[i] == i_lk_pc && r_dir[i] == i_lk_dir) begin
            o_hit    = 1'b1;
            o_target = r_tgt[i];
          end
          if (r_valid[i] && r_pc[i] == i_ins_pc && r_dir[i] == i_ins_dir) begin
            w_match     = 1'b1;
            w_match_idx = IDX_W'(i);
          end
        end
      end

      // Overwriting a present key leaves the round-robin pointer untouched.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_pc[i]    <= '0;
            r_dir[i]   <= DIR_FWD;
            r_tgt[i]   <= '0;
          end
          r_rr <= '0;
        end else if (i_flush) begin
          for (int unsigned i = 0; i < CACHE_ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
          end
        end else if (i_ins) begin
          if (w_match) begin
            r_tgt[w_match_idx] <= i_ins_target;
          end else begin
            r_valid[r_rr] <= 1'b1;
            r_pc[r_rr]    <= i_ins_pc;
            r_dir[r_rr]   <= i_ins_dir;
            r_tgt[r_rr]   <= i_ins_target;
            r_rr          <= (r_rr == IDX_W'(LAST)) ? '0 : r_rr + 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/branch_scanner.sv
// Sequential CBF/CBB bracket matcher: walks program memory tracking nesting depth,
// with a jump-target cache so repeated branches resolve without a walk.
module branch_scanner
  import definitions::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DEPTH_W       = 8,
  parameter int unsigned CACHE_ENTRIES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue,
  input  op_code            instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic              acc_zero,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  op_code            mem_data,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic [ADDR_W-1:0] target_pc,
  output logic              error
);

  scan_state_e        r_state, w_next;
  logic [ADDR_W-1:0]  r_pc, r_addr, r_target;
  scan_dir_e          r_dir;
  logic [DEPTH_W-1:0] r_depth, w_depth_next;
  logic               r_mem_req, r_taken, r_error, r_flushed;

  scan_dir_e          w_issue_dir;
  logic               w_is_branch, w_cond, w_accept, w_init_edge, w_start_scan;
  logic [ADDR_W-1:0]  w_init_addr, w_step_addr, w_hit_target;
  logic               w_hit, w_same, w_opp, w_ack, w_found, w_err, w_addr_edge, w_insert;

  assign w_is_branch  = (instr == CBF) || (instr == CBB);
  assign w_issue_dir  = branch_dir(instr);
  assign w_cond       = (instr == CBF) ? acc_zero : !acc_zero;
  assign w_accept     = (r_state == S_IDLE) && issue && w_is_branch;
  assign w_init_addr  = (w_issue_dir == DIR_FWD) ? pc + 1'b1 : pc - 1'b1;
  assign w_init_edge  = (w_issue_dir == DIR_FWD) ? (&pc) : (pc == '0);
  assign w_start_scan = w_cond && !w_hit && !w_init_edge;

  assign w_same       = (r_dir == DIR_FWD) ? (mem_data == CBF) : (mem_data == CBB);
  assign w_opp        = (r_dir == DIR_FWD) ? (mem_data == CBB) : (mem_data == CBF);
  assign w_depth_next = w_same ? r_depth + 1'b1 : (w_opp ? r_depth - 1'b1 : r_depth);
  assign w_addr_edge  = (r_dir == DIR_FWD) ? (&r_addr) : (r_addr == '0);
  assign w_step_addr  = (r_dir == DIR_FWD) ? r_addr + 1'b1 : r_addr - 1'b1;
  assign w_ack        = (r_state == S_SCAN) && mem_ack;
  assign w_found      = w_ack && w_opp && (r_depth == DEPTH_W'(1));
  // Depth overflow and address wrap are the only scan failures; a match wins over a wrap.
  assign w_err        = w_ack && ((w_same && (&r_depth)) || (!w_found && w_addr_edge));
  assign w_insert     = w_found && !r_flushed;

  jump_target_cache #(
    .ADDR_W       (ADDR_W),
    .CACHE_ENTRIES(CACHE_ENTRIES)
  ) u_cache (
    .i_clk       (clock),
    .i_rst_n     (reset_n),
    .i_flush     (flush),
    .i_lk_pc     (pc),
    .i_lk_dir    (w_issue_dir),
    .o_hit       (w_hit),
    .o_target    (w_hit_target),
    .i_ins       (w_insert),
    .i_ins_pc    (r_pc),
    .i_ins_dir   (r_dir),
    .i_ins_target(r_addr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_accept) w_next = w_start_scan ? S_SCAN : S_RESOLVE;
      S_SCAN:    if (w_found || w_err) w_next = S_RESOLVE;
      S_RESOLVE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_RESOLVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= '0;
      r_dir     <= DIR_FWD;
      r_depth   <= '0;
      r_addr    <= '0;
      r_mem_req <= 1'b0;
      r_taken   <= 1'b0;
      r_target  <= '0;
      r_error   <= 1'b0;
      r_flushed <= 1'b0;
    end else if (w_accept) begin
      r_pc      <= pc;
      r_dir     <= w_issue_dir;
      r_flushed <= 1'b0;
      r_error   <= 1'b0;
      r_taken   <= 1'b0;
      r_target  <= pc;
      if (w_cond && w_hit) begin
        r_taken  <= 1'b1;
        r_target <= w_hit_target;
      end else if (w_cond && w_init_edge) begin
        r_error <= 1'b1;
      end else if (w_cond) begin
        r_depth   <= DEPTH_W'(1);
        r_addr    <= w_init_addr;
        r_mem_req <= 1'b1;
      end
    end else if (r_state == S_SCAN) begin
      if (flush) r_flushed <= 1'b1;
      if (w_err) begin
        r_mem_req <= 1'b0;
        r_error   <= 1'b1;
        r_taken   <= 1'b0;
        r_target  <= r_pc;
      end else if (w_found) begin
        r_mem_req <= 1'b0;
        r_taken   <= 1'b1;
        r_target  <= r_addr;
      end else if (w_ack) begin
        r_depth <= w_depth_next;
        r_addr  <= w_step_addr;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_addr  = r_addr;
  assign taken     = r_taken;
  assign target_pc = r_target;
  assign error     = r_error;

endmodule

// File: tb/tb_branch_scanner.sv
// Self-checking bench for branch_scanner: directed table, hand sequences, random vs. model.
module tb_branch_scanner;
  import definitions::*;

  localparam int LIM  = 3000;
  localparam int DMAX = 255;
  localparam int CN   = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, issue, acc_zero, flush, mem_req, mem_ack, busy, done, taken, error;
  op_code      instr, mem_data;
  logic [15:0] pc, mem_addr, target_pc;

  logic        issue2, acc2, flush2, req2, ack2, busy2, done2, taken2, err2;
  op_code      instr2, data2;
  logic [15:0] pc2, addr2, tgt2;

  op_code mem [65536];

  branch_scanner dut (
    .clock(clock), .reset_n(reset_n), .issue(issue), .instr(instr), .pc(pc),
    .acc_zero(acc_zero), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy), .done(done),
    .taken(taken), .target_pc(target_pc), .error(error)
  );

  branch_scanner #(.DEPTH_W(2), .CACHE_ENTRIES(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .issue(issue2), .instr(instr2), .pc(pc2),
    .acc_zero(acc2), .flush(flush2), .mem_req(req2), .mem_addr(addr2),
    .mem_ack(ack2), .mem_data(data2), .busy(busy2), .done(done2),
    .taken(taken2), .target_pc(tgt2), .error(err2)
  );

  assign ack2  = req2;
  assign data2 = mem[addr2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder with a programmable ack delay; logs every fetched address.
  int          ack_delay = 0;
  int          req_cycles = 0;
  int          instab = 0;
  int          wcnt = 0;
  logic        prev_req = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [15:0] fetched[$];

  initial begin
    mem_ack  = 1'b0;
    mem_data = NOP;
    forever begin
      @(posedge clock);
      #1;
      if (mem_ack) wcnt = 0;
      else if (mem_req && prev_req && mem_addr !== prev_addr) instab++;
      mem_ack = 1'b0;
      if (mem_req) begin
        req_cycles++;
        if (wcnt >= ack_delay) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          fetched.push_back(mem_addr);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
  end

  // Reference model: bracket walk over the memory array plus a FIFO-ordered cache.
  typedef struct {
    logic [15:0] pc;
    bit          fwd;
    logic [15:0] tgt;
  } ce_t;
  ce_t         cq[$];
  logic [15:0] exp_addrs[$];

  task automatic cache_insert(input logic [15:0] p, input bit fwd, input logic [15:0] t);
    for (int i = 0; i < cq.size(); i++) begin
      if (cq[i].pc == p && cq[i].fwd == fwd) begin
        cq[i].tgt = t;
        return;
      end
    end
    if (cq.size() == CN) void'(cq.pop_front());
    cq.push_back('{pc: p, fwd: fwd, tgt: t});
  endtask

  task automatic model_run(input op_code ins, input logic [15:0] p, input logic acc,
                           output logic t, output logic [15:0] tgt, output logic e);
    bit fwd;
    bit stop;
    int d;
    int a;
    fwd = (ins == CBF);
    t   = 1'b0;
    tgt = p;
    e   = 1'b0;
    exp_addrs.delete();
    if (fwd ? !acc : acc) return;
    for (int i = 0; i < cq.size(); i++) begin
      if (cq[i].pc == p && cq[i].fwd == fwd) begin
        t   = 1'b1;
        tgt = cq[i].tgt;
        return;
      end
    end
    d    = 1;
    a    = int'(p);
    stop = 1'b0;
    while (!stop) begin
      a = fwd ? a + 1 : a - 1;
      if (a < 0 || a > 65535) begin
        e    = 1'b1;
        stop = 1'b1;
      end else begin
        exp_addrs.push_back(16'(a));
        if (mem[a] == ins) begin
          d++;
          if (d > DMAX) begin
            e    = 1'b1;
            stop = 1'b1;
          end
        end else if (mem[a] == (fwd ? CBB : CBF)) begin
          d--;
          if (d == 0) begin
            t    = 1'b1;
            tgt  = 16'(a);
            cache_insert(p, fwd, tgt);
            stop = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic run_branch(input string name, input op_code ins, input logic [15:0] p,
                            input logic acc, input int dly, input bit fl_mid, input bit glitch,
                            input bit use_model, input logic et, input logic [15:0] etgt,
                            input logic ee, input int en);
    logic        mt, me;
    logic [15:0] mtgt;
    int          lat;
    int          elat;
    bit          same;
    model_run(ins, p, acc, mt, mtgt, me);
    if (use_model) begin
      et   = mt;
      etgt = mtgt;
      ee   = me;
      en   = exp_addrs.size();
    end
    ack_delay = dly;
    @(posedge clock);
    #1;
    fetched.delete();
    req_cycles = 0;
    instab     = 0;
    issue      = 1'b1;
    instr      = ins;
    pc         = p;
    acc_zero   = acc;
    @(posedge clock);
    #1;
    issue = 1'b0;
    instr = NOP;
    check({name, ".busy"}, busy, 1);
    lat = 1;
    while (!done && lat < LIM) begin
      if (lat == 1) begin
        flush = fl_mid;
        if (glitch) begin
          issue    = 1'b1;
          instr    = CBB;
          pc       = 16'h0040;
          acc_zero = 1'b0;
        end
      end
      @(posedge clock);
      #1;
      flush = 1'b0;
      issue = 1'b0;
      lat++;
    end
    elat = (en == 0) ? 1 : en * (dly + 1) + 1;
    check({name, ".done"}, done, 1);
    check({name, ".taken"}, taken, et);
    check({name, ".target"}, target_pc, etgt);
    check({name, ".error"}, error, ee);
    check({name, ".latency"}, lat, elat);
    check({name, ".fetches"}, fetched.size(), en);
    same = (fetched.size() == exp_addrs.size());
    for (int i = 0; i < fetched.size() && i < exp_addrs.size(); i++)
      if (fetched[i] !== exp_addrs[i]) same = 1'b0;
    check({name, ".addrs"}, same, 1);
    check({name, ".addr_stable"}, instab, 0);
    if (en == 0) check({name, ".no_req"}, req_cycles, 0);
    @(posedge clock);
    #1;
    check({name, ".idle"}, {busy, done}, 0);
    if (fl_mid) cq.delete();
  endtask

  task automatic run2(input string name, input op_code ins, input logic [15:0] p, input logic acc,
                      input logic et, input logic [15:0] etgt, input logic ee, input int elat);
    int lat;
    @(posedge clock);
    #1;
    issue2 = 1'b1;
    instr2 = ins;
    pc2    = p;
    acc2   = acc;
    @(posedge clock);
    #1;
    issue2 = 1'b0;
    lat    = 1;
    while (!done2 && lat < LIM) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check({name, ".done"}, done2, 1);
    check({name, ".taken"}, taken2, et);
    check({name, ".target"}, tgt2, etgt);
    check({name, ".error"}, err2, ee);
    check({name, ".latency"}, lat, elat);
  endtask

  typedef struct {
    string       name;
    op_code      ins;
    logic [15:0] pc;
    logic        acc;
    int          dly;
    logic        t;
    logic [15:0] tgt;
    logic        e;
    int          n;
  } vec_t;

  vec_t tbl[10];

  function automatic op_code rand_op();
    case ($urandom_range(0, 9))
      0, 1, 2: return CBF;
      3, 4, 5: return CBB;
      6:       return INC_ACC;
      7:       return DEC_DP;
      default: return NOP;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pool[8];
    logic mt, me;
    logic [15:0] mtgt;

    tbl[0] = '{"nt_cbf",     CBF, 16'h0010, 1'b0, 0, 1'b0, 16'h0010, 1'b0, 0};
    tbl[1] = '{"fwd_nested", CBF, 16'h0010, 1'b1, 0, 1'b1, 16'h0015, 1'b0, 5};
    tbl[2] = '{"bwd_nested", CBB, 16'h0015, 1'b0, 1, 1'b1, 16'h0010, 1'b0, 5};
    tbl[3] = '{"fwd_hit",    CBF, 16'h0010, 1'b1, 0, 1'b1, 16'h0015, 1'b0, 0};
    tbl[4] = '{"bwd_hit",    CBB, 16'h0015, 1'b0, 0, 1'b1, 16'h0010, 1'b0, 0};
    tbl[5] = '{"nt_cbb",     CBB, 16'h0015, 1'b1, 0, 1'b0, 16'h0015, 1'b0, 0};
    tbl[6] = '{"wrap_fwd",   CBF, 16'hFFFE, 1'b1, 0, 1'b0, 16'hFFFE, 1'b1, 1};
    tbl[7] = '{"wrap_bwd",   CBB, 16'h0001, 1'b0, 2, 1'b0, 16'h0001, 1'b1, 1};
    tbl[8] = '{"wrap_now",   CBB, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 0};
    tbl[9] = '{"wrap_again", CBF, 16'hFFFE, 1'b1, 0, 1'b0, 16'hFFFE, 1'b1, 1};

    for (int i = 0; i < 65536; i++) mem[i] = NOP;
    mem[16'h0010] = CBF; mem[16'h0011] = NOP; mem[16'h0012] = CBF;
    mem[16'h0013] = NOP; mem[16'h0014] = CBB; mem[16'h0015] = CBB;
    for (int i = 16'h0100; i < 16'h0200; i++) mem[i] = CBF;
    for (int i = 16'h0240; i < 16'h0340; i++) mem[i] = CBB;
    for (int i = 16'h0200; i < 16'h0240; i++) mem[i] = rand_op();
    mem[16'h0501] = CBF; mem[16'h0502] = CBF; mem[16'h0503] = CBF;

    issue = 1'b0; instr = NOP; pc = '0; acc_zero = 1'b0; flush = 1'b0;
    issue2 = 1'b0; instr2 = NOP; pc2 = '0; acc2 = 1'b0; flush2 = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset.outputs", {mem_req, busy, done, taken, error}, 0);
    check("reset.addr_target", {mem_addr, target_pc}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_branch(tbl[i].name, tbl[i].ins, tbl[i].pc, tbl[i].acc, tbl[i].dly, 1'b0, 1'b0, 1'b0,
                 tbl[i].t, tbl[i].tgt, tbl[i].e, tbl[i].n);

    // Idle flush, then a flush during the scan keeps the result out of the cache.
    @(posedge clock); #1; flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    cq.delete();
    run_branch("after_flush", CBF, 16'h0010, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0015, 1'b0, 5);
    run_branch("slow_ack", CBF, 16'h0010, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0015, 1'b0, 5);
    run_branch("slow_hit", CBF, 16'h0010, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 1'b0, 0);

    @(posedge clock); #1;
    issue = 1'b1; instr = INC_ACC; pc = 16'h0010; acc_zero = 1'b1;
    @(posedge clock); #1;
    issue = 1'b0; instr = NOP;
    for (int i = 0; i < 3; i++) begin
      check("non_branch.ignored", {busy, done, mem_req}, 0);
      @(posedge clock); #1;
    end

    // Reset in the middle of a backward scan.
    ack_delay = 3;
    @(posedge clock); #1;
    issue = 1'b1; instr = CBB; pc = 16'h0015; acc_zero = 1'b0;
    @(posedge clock); #1;
    issue = 1'b0; instr = NOP;
    check("midreset.scanning", mem_req, 1);
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset.outputs", {mem_req, busy, done, taken, error}, 0);
    check("midreset.addr_target", {mem_addr, target_pc}, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cq.delete();
    run_branch("post_reset_miss", CBF, 16'h0010, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0015, 1'b0, 5);

    for (int i = 0; i < 8; i++) pool[i] = 16'h0200 + $urandom_range(0, 63);
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clock); #1; flush = 1'b1;
        @(posedge clock); #1; flush = 1'b0;
        cq.delete();
      end
      if ($urandom_range(0, 9) == 0) mem[16'h0200 + $urandom_range(0, 63)] = rand_op();
      run_branch($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1) ? CBF : CBB,
                 16'(pool[$urandom_range(0, 7)]), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 0);
    end

    run2("d2_overflow", CBF, 16'h0500, 1'b1, 1'b0, 16'h0500, 1'b1, 4);
    run2("d2_nested_a", CBF, 16'h0010, 1'b1, 1'b1, 16'h0015, 1'b0, 6);
    run2("d2_nested_b", CBF, 16'h0010, 1'b1, 1'b1, 16'h0015, 1'b0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
